flow_director_cfg_ctrl: RTL
===========================

Name: flow_director_cfg_ctrl

Overview:
Sequences run-time reconfiguration of the flow director's fallback-queue settings (nb_fallback_queues, enable_rr) without disturbing packets in flight. It sits between the CSR block and the flow director, and gates the metadata handshake into the director. On a config write it validates the values, quiesces the metadata path and drains in-flight packets. It then applies the new settings atomically and clears the round-robin pointer.

Parameters:
MAX_FALLBACK_QUEUES, 8192, largest legal nb_fallback_queues value (power of two)
INFLIGHT_W, 16, width of the in-flight packet counter
DRAIN_TIMEOUT, 4096, maximum number of BLOCK cycles before a drain is aborted
RESET_NB_FALLBACK, 1, nb_fallback_queues value after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
cfg_wr_valid  in  1  config write request
cfg_wr_ready  out  1  config write accepted when high with valid
cfg_wr_nb_fallback_queues  in  32  requested fallback queue count
cfg_wr_enable_rr  in  1  requested round-robin enable
cfg_resp_valid  out  1  one-cycle response pulse
cfg_resp_code  out  2  00 OK, 01 INVALID, 10 TIMEOUT; valid with cfg_resp_valid
up_meta_valid  in  1  upstream metadata valid
up_meta_ready  out  1  ready to upstream
fd_meta_valid  out  1  valid into flow director
fd_meta_ready  in  1  flow director ready
pkt_done  in  1  one pulse per packet retired downstream of the director
nb_fallback_queues  out  32  applied config, registered
enable_rr  out  1  applied config, registered
rr_clear  out  1  one-cycle pulse; clears the director's RR pointer
inflight_underflow  out  1  sticky error flag

Behaviour:
- Reset values:
  - state RUN; nb_fallback_queues=RESET_NB_FALLBACK; enable_rr=0.
  - rr_clear=0, cfg_resp_valid=0, cfg_resp_code=00, inflight_underflow=0.
  - inflight counter=0, drain counter=0.
  - Reset mid-drain abandons the pending write; no response is issued.
- meta_fire = fd_meta_valid & fd_meta_ready.
- Inflight counter:
  - +1 on meta_fire, -1 on pkt_done; both in the same cycle leaves it unchanged.
  - pkt_done with count 0 and no fire: count stays 0 and inflight_underflow is set (sticky until rst).
- Gating, RUN:
  - fd_meta_valid = up_meta_valid.
  - up_meta_ready = fd_meta_ready & (inflight != all-ones).
  - fd_meta_valid is also forced 0 at all-ones, so the counter never overflows.
- Gating, BLOCK and APPLY: fd_meta_valid=0, up_meta_ready=0.
- cfg_wr_ready = (state==RUN) & ~(up_meta_valid & ~fd_meta_ready). A stalled beat is never withdrawn. A meta_fire in the acceptance cycle counts as in flight.
- Validation at acceptance. INVALID if either holds:
  - nb > MAX_FALLBACK_QUEUES;
  - nb != 0 and (nb & (nb-1)) != 0.
- On an INVALID write: state stays RUN, config is unchanged, and cfg_resp_valid/code=01 are asserted the next cycle.
- nb=0 is legal; the director then drops unmatched packets.
- Valid write: latch the pending values and go to BLOCK the next cycle; clear the drain counter.
- BLOCK:
  - Each cycle: if inflight==0 (after that cycle's pkt_done), go to APPLY.
  - Otherwise, if drain counter == DRAIN_TIMEOUT-1, go to RUN and pulse response 10 the next cycle; config is unchanged.
  - Otherwise the drain counter increments.
  - inflight==0 has priority over timeout in the same cycle.
- APPLY (exactly 1 cycle): write pending values into the output registers, then go to RUN.
- In the first RUN cycle after APPLY, all of the following hold together:
  - new config is visible;
  - rr_clear=1;
  - cfg_resp_valid=1, code 00;
  - gate reopens.
- Write-to-resume latency when already drained is 3 cycles: accept, BLOCK, APPLY, then RUN.
- A write identical to the current config still performs the full sequence, including rr_clear.
- cfg_wr_ready=0 outside RUN; there is no write queueing.

Decomposition:
- Shared package (constants.sv): cfg_resp_code_t enum (CFG_OK, CFG_INVALID, CFG_TIMEOUT) and the cfg_ctrl_state_t enum (RUN, BLOCK, APPLY).
- Single module, no sub-module. The flow director gains an rr_clear input, ORed with rst on its RR pointer.

Test Plan:
1. Reset then idle: nb_fallback_queues=1, enable_rr=0, cfg_wr_ready=1, no response.
2. Write nb=16, rr=1, inflight 0: BLOCK 1 cycle, APPLY 1 cycle; next cycle nb=16, rr=1, rr_clear=1, resp 00; fd_meta_valid=0 for exactly 2 cycles.
3. Write nb=12, then nb=16384: each gives resp 01 next cycle, config unchanged, no gating.
4. 5 packets in flight, write nb=4; pkt_done pulses at +10..+14: gate held until last done, APPLY, resp 00; upstream beats held and none lost.
5. 1 packet in flight, never retired, DRAIN_TIMEOUT=4096: resp 10 after 4096 BLOCK cycles, old config kept, traffic resumes.
6. Simultaneous meta_fire and pkt_done at count 3 stays 3; pkt_done at count 0 gives inflight_underflow=1 and count 0; rst mid-BLOCK returns to reset values with no response.

Source files
------------

// File: rtl/flow_director_cfg_ctrl_pkg.sv
// Shared types and helpers for the flow director configuration controller.
//   cfg_resp_code_t  : response code returned for each accepted config write
//   cfg_ctrl_state_t : sequencing state (RUN / BLOCK / APPLY)
//   nb_is_legal()    : fallback queue count check (zero or a power of two, not above max)
package flow_director_cfg_ctrl_pkg;

   localparam int unsigned MAX_FALLBACK_QUEUES_DEF = 8192;
   localparam int unsigned INFLIGHT_W_DEF          = 16;
   localparam int unsigned DRAIN_TIMEOUT_DEF       = 4096;
   localparam int unsigned RESET_NB_FALLBACK_DEF   = 1;

   typedef enum logic [1:0] {
      CFG_OK      = 2'b00,
      CFG_INVALID = 2'b01,
      CFG_TIMEOUT = 2'b10
   } cfg_resp_code_t;

   typedef enum logic [1:0] {
      RUN   = 2'b00,
      BLOCK = 2'b01,
      APPLY = 2'b10
   } cfg_ctrl_state_t;

   // Zero is legal (director drops unmatched packets); otherwise a single set bit.
   function automatic logic nb_is_legal(input logic [31:0] nb, input logic [31:0] max_nb);
      return (nb <= max_nb) && ((nb & (nb - 32'd1)) == 32'd0);
   endfunction

endpackage

// File: rtl/flow_director_cfg_ctrl_if.sv
// Handshake bundle between CSR block, upstream metadata source, flow director
// and the configuration controller.
//
// Handshake rules: a transfer happens on a rising clk edge where valid and
// ready are both high. A producer holding valid high keeps it and its data
// stable until the transfer happens; ready may change freely. cfg_resp_valid
// and pkt_done are single-cycle pulses with no back-pressure.
//
//   master : CSR + upstream + director side (drives requests, pkt_done, fd_meta_ready)
//   slave  : the configuration controller
interface flow_director_cfg_ctrl_if;
   logic        cfg_wr_valid;
   logic        cfg_wr_ready;
   logic [31:0] cfg_wr_nb_fallback_queues;
   logic        cfg_wr_enable_rr;
   logic        cfg_resp_valid;
   logic [1:0]  cfg_resp_code;
   logic        up_meta_valid;
   logic        up_meta_ready;
   logic        fd_meta_valid;
   logic        fd_meta_ready;
   logic        pkt_done;

   modport master (
      output cfg_wr_valid, cfg_wr_nb_fallback_queues, cfg_wr_enable_rr,
      output up_meta_valid, fd_meta_ready, pkt_done,
      input  cfg_wr_ready, cfg_resp_valid, cfg_resp_code,
      input  up_meta_ready, fd_meta_valid
   );

   modport slave (
      input  cfg_wr_valid, cfg_wr_nb_fallback_queues, cfg_wr_enable_rr,
      input  up_meta_valid, fd_meta_ready, pkt_done,
      output cfg_wr_ready, cfg_resp_valid, cfg_resp_code,
      output up_meta_ready, fd_meta_valid
   );
endinterface

// File: rtl/flow_director_cfg_ctrl.sv
// Run-time reconfiguration sequencer for the flow director fallback settings.
// A config write is validated, the metadata path into the director is closed,
// in-flight packets are drained, then the new settings are applied atomically
// together with an rr_clear pulse and an OK response.
//
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   bus (slave)         : config write/response, metadata gate, pkt_done
//   nb_fallback_queues  : applied fallback queue count (registered)
//   enable_rr           : applied round-robin enable (registered)
//   rr_clear            : one-cycle pulse clearing the director RR pointer
//   inflight_underflow  : sticky, pkt_done seen with nothing in flight
//   state_dbg           : current sequencing state
//   inflight_dbg        : current in-flight packet count
module flow_director_cfg_ctrl
   import flow_director_cfg_ctrl_pkg::*;
#(
   parameter int unsigned MAX_FALLBACK_QUEUES = MAX_FALLBACK_QUEUES_DEF,
   parameter int unsigned INFLIGHT_W          = INFLIGHT_W_DEF,
   parameter int unsigned DRAIN_TIMEOUT       = DRAIN_TIMEOUT_DEF,
   parameter int unsigned RESET_NB_FALLBACK   = RESET_NB_FALLBACK_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   flow_director_cfg_ctrl_if.slave bus,
   output logic [31:0]           nb_fallback_queues,
   output logic                  enable_rr,
   output logic                  rr_clear,
   output logic                  inflight_underflow,
   output cfg_ctrl_state_t       state_dbg,
   output logic [INFLIGHT_W-1:0] inflight_dbg
);

   localparam int unsigned DRAIN_W = (DRAIN_TIMEOUT > 1) ? $clog2(DRAIN_TIMEOUT) : 1;

   cfg_ctrl_state_t       state_q, state_d;
   logic [INFLIGHT_W-1:0] inflight_q, inflight_d;
   logic [DRAIN_W-1:0]    drain_q, drain_d;
   logic [31:0]           pend_nb_q;
   logic                  pend_rr_q;
   logic                  resp_valid_q;
   cfg_resp_code_t        resp_code_q;
   logic                  resp_fire_d;
   cfg_resp_code_t        resp_code_d;
   logic                  in_run;
   logic                  inflight_full;
   logic                  meta_fire;
   logic                  wr_fire;
   logic                  wr_legal;
   logic                  underflow_evt;

   // Metadata gate. At an all-ones count the gate closes so the counter cannot wrap.
   assign in_run            = (state_q == RUN);
   assign inflight_full     = &inflight_q;
   assign bus.fd_meta_valid = in_run & bus.up_meta_valid & ~inflight_full;
   assign bus.up_meta_ready = in_run & bus.fd_meta_ready & ~inflight_full;
   // Refuse a write while an upstream beat is stalled, so closing the gate
   // never withdraws an already-presented valid.
   assign bus.cfg_wr_ready  = in_run & ~(bus.up_meta_valid & ~bus.fd_meta_ready);

   assign meta_fire = bus.fd_meta_valid & bus.fd_meta_ready;
   assign wr_fire   = bus.cfg_wr_valid & bus.cfg_wr_ready;
   assign wr_legal  = nb_is_legal(bus.cfg_wr_nb_fallback_queues, 32'(MAX_FALLBACK_QUEUES));

   assign bus.cfg_resp_valid = resp_valid_q;
   assign bus.cfg_resp_code  = resp_code_q;
   assign state_dbg          = state_q;
   assign inflight_dbg       = inflight_q;

   always_comb begin
      inflight_d    = inflight_q;
      underflow_evt = 1'b0;
      case ({meta_fire, bus.pkt_done})
         2'b10: inflight_d = inflight_q + 1'b1;
         2'b01: begin
            if (inflight_q == '0) underflow_evt = 1'b1;
            else                  inflight_d    = inflight_q - 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= RUN;
      else     state_q <= state_d;
   end

   // Drain completion looks at the count after this cycle's pkt_done and
   // wins over the timeout.
   always_comb begin
      state_d     = state_q;
      drain_d     = drain_q;
      resp_fire_d = 1'b0;
      resp_code_d = CFG_OK;
      case (state_q)
         RUN: begin
            if (wr_fire) begin
               if (wr_legal) begin
                  state_d = BLOCK;
                  drain_d = '0;
               end else begin
                  resp_fire_d = 1'b1;
                  resp_code_d = CFG_INVALID;
               end
            end
         end
         BLOCK: begin
            if (inflight_d == '0) begin
               state_d = APPLY;
            end else if (drain_q == DRAIN_W'(DRAIN_TIMEOUT - 1)) begin
               state_d     = RUN;
               resp_fire_d = 1'b1;
               resp_code_d = CFG_TIMEOUT;
            end else begin
               drain_d = drain_q + 1'b1;
            end
         end
         APPLY: begin
            state_d     = RUN;
            resp_fire_d = 1'b1;
            resp_code_d = CFG_OK;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight_q         <= '0;
         drain_q            <= '0;
         inflight_underflow <= 1'b0;
         pend_nb_q          <= 32'(RESET_NB_FALLBACK);
         pend_rr_q          <= 1'b0;
         resp_valid_q       <= 1'b0;
         resp_code_q        <= CFG_OK;
         rr_clear           <= 1'b0;
         nb_fallback_queues <= 32'(RESET_NB_FALLBACK);
         enable_rr          <= 1'b0;
      end else begin
         inflight_q   <= inflight_d;
         drain_q      <= drain_d;
         resp_valid_q <= resp_fire_d;
         rr_clear     <= (state_q == APPLY);
         if (underflow_evt)      inflight_underflow <= 1'b1;
         if (resp_fire_d)        resp_code_q        <= resp_code_d;
         if (wr_fire & wr_legal) begin
            pend_nb_q <= bus.cfg_wr_nb_fallback_queues;
            pend_rr_q <= bus.cfg_wr_enable_rr;
         end
         if (state_q == APPLY) begin
            nb_fallback_queues <= pend_nb_q;
            enable_rr          <= pend_rr_q;
         end
      end
   end

endmodule
